// File: rtl/mac_array_ofifo.sv
// Per-column psum FIFOs that realign skewed mac_array outputs into whole rows.
// Rows are popped together through a first-word-fall-through read port.
module mac_array_ofifo #(
    parameter int psum_bw = 32,
    parameter int col     = 2,
    parameter int depth   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   overflow
);

    localparam int aw = $clog2(depth);
    localparam logic [aw:0] one = 1;

    logic [aw:0]        wr_ptr [col];
    logic [aw:0]        rd_ptr [col];
    logic [psum_bw-1:0] mem    [col][depth];

    logic [col-1:0] full;
    logic [col-1:0] empty;
    logic [col-1:0] accept;
    logic           pop;

    always_comb begin
        full  = '0;
        empty = '0;
        for (int c = 0; c < col; c++) begin
            empty[c] = (wr_ptr[c] == rd_ptr[c]);
            full[c]  = (wr_ptr[c][aw] != rd_ptr[c][aw]) &&
                       (wr_ptr[c][aw-1:0] == rd_ptr[c][aw-1:0]);
        end
    end

    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    // A pop in the same edge frees a slot, so a full column may still accept
    assign accept = wr & (~full | {col{pop}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < col; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
            overflow <= 1'b0;
        end else begin
            for (int c = 0; c < col; c++) begin
                if (accept[c])
                    wr_ptr[c] <= wr_ptr[c] + one;
                if (pop)
                    rd_ptr[c] <= rd_ptr[c] + one;
            end
            if (!pop && |(wr & full))
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (accept[c])
                mem[c][wr_ptr[c][aw-1:0]] <= in[psum_bw*c +: psum_bw];
        end
    end

    always_comb begin
        out = '0;
        if (o_valid) begin
            for (int c = 0; c < col; c++)
                out[psum_bw*c +: psum_bw] = mem[c][rd_ptr[c][aw-1:0]];
        end
    end

endmodule

// File: tb/tb_mac_array_ofifo.sv
// Directed and random bench for mac_array_ofifo against a queue-based model.
// Every cycle compares flags and the head row with the model's expectation.
module tb_mac_array_ofifo;

    localparam int BW = 32;
    localparam int C  = 2;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [BW*C-1:0] din = '0;
    logic [C-1:0]  wr = '0;
    logic          rd = 1'b0;
    logic [BW*C-1:0] dout;
    logic          o_valid;
    logic          o_full;
    logic          o_ready;
    logic          overflow;

    int checks = 0;
    int failures = 0;

    logic [BW-1:0] q [C][$];
    logic          m_ovf = 1'b0;
    logic [BW*C-1:0] last_pop;

    mac_array_ofifo #(.psum_bw(BW), .col(C), .depth(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (din),
        .wr       (wr),
        .rd       (rd),
        .out      (dout),
        .o_valid  (o_valid),
        .o_full   (o_full),
        .o_ready  (o_ready),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW*C-1:0] obs,
                       input logic [BW*C-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_valid();
        return q[0].size() > 0 && q[1].size() > 0;
    endfunction

    task automatic check_all(input string tag);
        logic [BW*C-1:0] e_out;
        logic e_full;
        e_out  = m_valid() ? {q[1][0], q[0][0]} : '0;
        e_full = (q[0].size() == D) || (q[1].size() == D);
        chk({tag, ".o_valid"}, {63'd0, o_valid}, {63'd0, m_valid()});
        chk({tag, ".o_full"}, {63'd0, o_full}, {63'd0, e_full});
        chk({tag, ".o_ready"}, {63'd0, o_ready}, {63'd0, !e_full});
        chk({tag, ".overflow"}, {63'd0, overflow}, {63'd0, m_ovf});
        chk({tag, ".out"}, dout, e_out);
    endtask

    // One clock: drive inputs, step the model at the edge, check after it
    task automatic cyc(input string tag, input logic [1:0] w,
                       input logic [BW-1:0] a, input logic [BW-1:0] b,
                       input logic r);
        logic p;
        logic [BW-1:0] d [C];
        logic [C-1:0] acc;
        wr  = w;
        din = {b, a};
        rd  = r;
        d[0] = a;
        d[1] = b;
        @(posedge clk);
        p = r && m_valid();
        if (p) last_pop = {q[1][0], q[0][0]};
        for (int c = 0; c < C; c++) begin
            acc[c] = w[c] && (q[c].size() < D || p);
            if (w[c] && q[c].size() == D && !p) m_ovf = 1'b1;
        end
        for (int c = 0; c < C; c++) begin
            if (p) void'(q[c].pop_front());
            if (acc[c]) q[c].push_back(d[c]);
        end
        #1;
        wr = '0;
        rd = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        q[0].delete();
        q[1].delete();
        m_ovf = 1'b0;
        check_all("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        last_pop = '0;
        @(posedge clk);
        #1;
        do_reset();
        cyc("idle_rd", 2'b00, 0, 0, 1'b1);

        // Skewed columns
        cyc("skew0", 2'b01, 32'd180, 0, 1'b0);
        chk("skew0.not_valid", {63'd0, o_valid}, 64'd0);
        cyc("skew1", 2'b10, 0, -32'sd180, 1'b0);
        chk("skew1.row", dout, {-32'sd180, 32'sd180});
        cyc("skew_pop", 2'b00, 0, 0, 1'b1);
        chk("skew_pop.ret", last_pop, {-32'sd180, 32'sd180});

        // Fill and wrap
        do_reset();
        for (int i = 1; i <= 4; i++)
            cyc("fill", 2'b11, BW'(i), BW'(i), 1'b0);
        chk("fill.full", {63'd0, o_full}, 64'd1);
        cyc("wrap_pop1", 2'b00, 0, 0, 1'b1);
        chk("wrap_pop1.ret", last_pop, {32'd1, 32'd1});
        cyc("wrap_pop2", 2'b00, 0, 0, 1'b1);
        chk("wrap_pop2.ret", last_pop, {32'd2, 32'd2});
        cyc("wrap_w5", 2'b11, 5, 5, 1'b0);
        cyc("wrap_w6", 2'b11, 6, 6, 1'b0);
        for (int i = 3; i <= 6; i++) begin
            cyc("wrap_drain", 2'b00, 0, 0, 1'b1);
            chk("wrap_drain.ret", last_pop, {BW'(i), BW'(i)});
        end

        // Overflow on col0
        do_reset();
        for (int i = 1; i <= 4; i++)
            cyc("ovf_fill", 2'b01, BW'(10 + i), 0, 1'b0);
        cyc("ovf_hit", 2'b01, 32'd99, 0, 1'b0);
        chk("ovf_hit.flag", {63'd0, overflow}, 64'd1);
        for (int i = 1; i <= 4; i++)
            cyc("ovf_col1", 2'b10, 0, BW'(20 + i), 1'b0);
        for (int i = 1; i <= 4; i++)
            cyc("ovf_drain", 2'b00, 0, 0, 1'b1);
        cyc("ovf_sticky", 2'b00, 0, 0, 1'b1);

        // Full pop + write
        do_reset();
        for (int i = 1; i <= 4; i++)
            cyc("fpw_fill", 2'b11, BW'(i), BW'(i), 1'b0);
        cyc("fpw_both", 2'b11, 7, 7, 1'b1);
        chk("fpw_both.full", {63'd0, o_full}, 64'd1);
        for (int i = 1; i <= 4; i++)
            cyc("fpw_drain", 2'b00, 0, 0, 1'b1);
        chk("fpw_last", last_pop, {32'd7, 32'd7});

        // Reset in the middle of a stream
        do_reset();
        cyc("mid_w1", 2'b11, 1, 1, 1'b0);
        cyc("mid_w2", 2'b11, 2, 2, 1'b0);
        reset = 1'b1;
        #1;
        chk("mid_async", {63'd0, o_valid}, 64'd0);
        q[0].delete();
        q[1].delete();
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("mid_w5", 2'b11, 5, 5, 1'b0);
        chk("mid_w5.row", dout, {32'd5, 32'd5});

        // Random traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cyc("rand", 2'($urandom_range(0, 3)), $urandom, $urandom,
                1'($urandom_range(0, 1)));
            if (n == 200) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
